// File: rtl/pc_gen.sv
// Fetch PC generator: holds the fetch PC, issues it as the BPU read request and
// redirects on backend flushes or BPU taken predictions (the latter only with BPU_REDIRECT_EN).
module pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    input  logic        fetch_ready,
    input  logic        predict_valid,
    input  logic [63:0] predict_target,
    input  logic [63:0] trigger_pc,
    output logic [63:0] pc,
    output logic        pc_valid,
    output logic        pc_handshake
);

    // state | meaning
    // BOOT  | out of reset, no request issued yet
    // RUN   | pc is a live request every cycle
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] pc_next;
    logic [63:0] last_pc;
    logic        pending;
    logic        take_pred;
    logic        unused_bits;

`ifdef BPU_REDIRECT_EN
    // The BPU answers one cycle after the handshake; only honour it for that exact PC.
    assign take_pred   = predict_valid & pending & (trigger_pc == last_pc);
    assign unused_bits = redirect_target[0];
`else
    assign take_pred   = 1'b0;
    assign unused_bits = ^{redirect_target[0], predict_valid, predict_target, trigger_pc,
                           pending, last_pc};
`endif

    assign pc_valid     = (state == RUN);
    assign pc_handshake = pc_valid & fetch_ready & ~redirect_valid & ~take_pred;

    always_comb begin
        state_next = RUN;
        pc_next    = pc;
        if (state == RUN) begin
            if (redirect_valid) begin
                pc_next = {redirect_target[63:1], 1'b0};
            end else if (take_pred) begin
                pc_next = predict_target;
            end else if (pc_handshake) begin
                // Advance to the next 8-byte fetch block, dropping any intra-block offset.
                pc_next = {pc[63:3] + 61'd1, 3'b000};
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= BOOT;
            pc      <= RESET_PC;
            pending <= 1'b0;
            last_pc <= 64'd0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            pending <= pc_handshake;
            if (pc_handshake) begin
                last_pc <= pc;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: each step pushes the expected outputs for that cycle,
// a negedge monitor pops and compares them. Expectations follow BPU_REDIRECT_EN.
module tb_pc_gen;

`ifdef BPU_REDIRECT_EN
    localparam bit PRED = 1'b1;
`else
    localparam bit PRED = 1'b0;
`endif

    localparam logic [63:0] RST = 64'h0000_0000_8000_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        fetch_ready;
    logic        predict_valid;
    logic [63:0] predict_target;
    logic [63:0] trigger_pc;
    logic [63:0] pc;
    logic        pc_valid;
    logic        pc_handshake;

    typedef struct {
        string       tag;
        logic [63:0] pc;
        logic        v;
        logic        hs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pc_gen dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .fetch_ready     (fetch_ready),
        .predict_valid   (predict_valid),
        .predict_target  (predict_target),
        .trigger_pc      (trigger_pc),
        .pc              (pc),
        .pc_valid        (pc_valid),
        .pc_handshake    (pc_handshake)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            assert (pc === e.pc) else begin
                errors++;
                $error("FAIL %s pc got %h want %h", e.tag, pc, e.pc);
            end
            checks++;
            assert (pc_valid === e.v) else begin
                errors++;
                $error("FAIL %s pc_valid got %b want %b", e.tag, pc_valid, e.v);
            end
            checks++;
            assert (pc_handshake === e.hs) else begin
                errors++;
                $error("FAIL %s pc_handshake got %b want %b", e.tag, pc_handshake, e.hs);
            end
        end
    end

    task automatic step(input string tag, input logic rv, input logic [63:0] rt,
                        input logic fr, input logic pv, input logic [63:0] pt,
                        input logic [63:0] tp, input logic [63:0] epc,
                        input logic ev, input logic ehs);
        exp_t e;
        redirect_valid  = rv;
        redirect_target = rt;
        fetch_ready     = fr;
        predict_valid   = pv;
        predict_target  = pt;
        trigger_pc      = tp;
        e.tag = tag;
        e.pc  = epc;
        e.v   = ev;
        e.hs  = ehs;
        sb.push_back(e);
        @(posedge clock);
        #1;
    endtask

    logic [63:0] p_after;
    logic [63:0] p_stall;

    initial begin
        reset_n         = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        fetch_ready     = 1'b1;
        predict_valid   = 1'b0;
        predict_target  = '0;
        trigger_pc      = '0;
        @(posedge clock);
        #1;

        step("reset", 0, 0, 1, 0, 0, 0, RST, 0, 0);
        reset_n = 1'b1;
        step("boot", 0, 0, 1, 0, 0, 0, RST, 0, 0);
        step("run0", 0, 0, 1, 0, 0, 0, RST, 1, 1);
        step("seq8", 0, 0, 1, 0, 0, 0, 64'h8000_0008, 1, 1);
        step("seq10", 0, 0, 1, 0, 0, 0, 64'h8000_0010, 1, 1);

        // Unaligned redirect target keeps its offset, then realigns on increment.
        step("redir_unal", 1, 64'h8000_0004, 1, 0, 0, 0, 64'h8000_0018, 1, 0);
        step("unal_hs", 0, 0, 1, 0, 0, 0, 64'h8000_0004, 1, 1);
        step("unal_next", 0, 0, 1, 0, 0, 0, 64'h8000_0008, 1, 1);
        step("hs_10", 0, 0, 1, 0, 0, 0, 64'h8000_0010, 1, 1);

        // Taken prediction for 0x8000_0010 one cycle after its handshake.
        step("pred_take", 0, 0, 1, 1, 64'h8000_0100, 64'h8000_0010,
             64'h8000_0018, 1, !PRED);
        p_after = PRED ? 64'h8000_0100 : 64'h8000_0020;
        step("post_pred", 0, 0, 1, 0, 0, 0, p_after, 1, 1);

        // Redirect wins over a matching prediction in the same cycle.
        step("redir_pred", 1, 64'h9000_0003, 1, 1, 64'h8000_0200, p_after,
             p_after + 64'd8, 1, 0);
        step("redir_land", 0, 0, 1, 0, 0, 0, 64'h9000_0002, 1, 1);

        // Stall at 0x8000_0020 with a stale prediction arriving mid-stall.
        step("redir_18", 1, 64'h8000_0018, 1, 0, 0, 0, 64'h9000_0008, 1, 0);
        step("hs_18", 0, 0, 1, 0, 0, 0, 64'h8000_0018, 1, 1);
        step("stall1", 0, 0, 0, 0, 0, 0, 64'h8000_0020, 1, 0);
        step("stall2", 0, 0, 0, 1, 64'h8000_0300, 64'h8000_0018, 64'h8000_0020, 1, 0);
        step("stall3", 0, 0, 0, 0, 0, 0, 64'h8000_0020, 1, 0);
        step("resume", 0, 0, 1, 0, 0, 0, 64'h8000_0020, 1, 1);
        // Pending but trigger_pc mismatches last_pc: ignored.
        step("mismatch", 0, 0, 1, 1, 64'h8000_0500, 64'h8000_0018, 64'h8000_0028, 1, 1);
        step("hs_30", 0, 0, 1, 0, 0, 0, 64'h8000_0030, 1, 1);

        // Prediction still applies in the first stall cycle.
        step("stall_pred", 0, 0, 0, 1, 64'h8000_0400, 64'h8000_0030, 64'h8000_0038, 1, 0);
        p_stall = PRED ? 64'h8000_0400 : 64'h8000_0038;
        step("stall_land", 0, 0, 1, 0, 0, 0, p_stall, 1, 1);

        // Sequential wrap at the top of the address space.
        step("redir_top", 1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 0, p_stall + 64'd8, 1, 0);
        step("top", 0, 0, 1, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, 1);
        step("wrap", 0, 0, 1, 0, 0, 0, 64'h0, 1, 1);

        // Back-to-back redirects: last one wins.
        step("b2b_a", 1, 64'h1000, 1, 0, 0, 0, 64'h8, 1, 0);
        step("b2b_b", 1, 64'h2001, 1, 0, 0, 0, 64'h1000, 1, 0);
        step("b2b_land", 0, 0, 1, 0, 0, 0, 64'h2000, 1, 1);

        // Reset mid-operation with a prediction in flight.
        reset_n = 1'b0;
        step("midrst", 0, 0, 1, 1, 64'h8000_0700, 64'h2000, RST, 0, 0);
        reset_n = 1'b1;
        step("midrst_boot", 0, 0, 1, 1, 64'h8000_0700, 64'h2000, RST, 0, 0);
        step("midrst_run", 0, 0, 1, 0, 0, 0, RST, 1, 1);
        step("midrst_seq", 0, 0, 1, 0, 0, 0, 64'h8000_0008, 1, 1);

        @(negedge clock);
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain queue got %0d want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Fetch PC generator for the frontend: holds the architectural fetch PC and presents it to the branch predictor and instruction fetch as a read request. It consumes the predictor's registered prediction one cycle after each request and redirects the PC to the predicted target, with backend redirects taking priority. It sits directly upstream of the BPU; the PC and handshake it drives are the BPU's read address and read enable.

## Interface
- RESET_PC, 64'h0000_0000_8000_0000, PC loaded at reset.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- redirect_valid  in  1  backend flush/redirect request.
- redirect_target  in  64  backend redirect PC.
- fetch_ready  in  1  fetch can accept a PC this cycle.
- predict_valid  in  1  BPU taken prediction valid.
- predict_target  in  64  BPU predicted target.
- trigger_pc  in  64  PC the BPU prediction belongs to.
- pc  out  64  current fetch PC, BPU read address.
- pc_valid  out  1  pc is a live request.
- pc_handshake  out  1  request accepted this cycle; BPU read enable.

## Operation
- States: BOOT and RUN.
  - Reset enters BOOT with pc_valid=0.
  - The first clock after reset release moves to RUN.
  - RUN is held until the next reset.
- pc_valid=1 in RUN.
- take_pred = predict_valid & pending & (trigger_pc == last_pc). This signal is combinational.
- pc_handshake = pc_valid & fetch_ready & ~redirect_valid & ~take_pred.
- On a handshake, last_pc <= pc. pending <= pc_handshake every cycle.
- Next-PC priority, evaluated at every edge in RUN:
  1. redirect_valid: pc <= {redirect_target[63:1],1'b0}.
  2. take_pred: pc <= predict_target.
  3. pc_handshake: pc <= {pc[63:3]+1, 3'b000}. This applies to both aligned and unaligned PCs.
  4. Otherwise pc holds.
- A redirect in the same cycle as take_pred discards the prediction.
- Sequential increment wraps 64'hFFFF_FFFF_FFFF_FFF8 to 0.
- A prediction whose trigger_pc mismatches last_pc, or that arrives with pending=0, is ignored.

## Timing
- Reset values:
  - pc = RESET_PC
  - pc_valid = 0, pc_handshake = 0
  - pending = 0, last_pc = 0
  - state = BOOT
- First possible handshake is the second rising edge after reset_n deasserts.
- BPU latency is 1 cycle:
  - Handshake of PC A in cycle N; prediction for A is evaluated in cycle N+1.
  - If taken, the N+1 handshake is suppressed and pc = target in cycle N+2.
  - The taken-branch bubble is exactly 1 cycle.
- Redirect: the cycle with redirect_valid has no handshake, and pc = redirect_target the next cycle with pc_valid=1, so there is no extra bubble. A redirect also clears pending for the following cycle.
- fetch_ready=0: pc holds, no handshake, and pending drops after one cycle. A prediction for the last accepted PC is still applied in the first stall cycle.
- Back-to-back redirects: each redirect overwrites pc and the last one wins.
- Reset asserted mid-operation: immediate return to the reset values, and any in-flight prediction is dropped.

## Configuration
- BPU_REDIRECT_EN
  - Defined: prediction path as described above.
  - Undefined: take_pred is tied to 0. predict_* and trigger_pc are unused, and the PC advances only sequentially or on backend redirect, with no prediction bubble.

## Test plan
- Reset with RESET_PC default, fetch_ready=1, no predictions: pc=0x8000_0000 after BOOT, then handshakes on 0x8000_0008 and 0x8000_0010 in consecutive cycles.
- Unaligned start: redirect to 0x8000_0004 gives a handshake at 0x8000_0004; next pc is 0x8000_0008.
- Handshake 0x8000_0010, then the next cycle predict_valid=1, trigger_pc=0x8000_0010, target=0x8000_0100: pc_handshake=0 that cycle, and the next pc is 0x8000_0100.
- redirect_valid with target 0x9000_0003 in the same cycle as a matching taken prediction: pc becomes 0x9000_0002 and the prediction is ignored.
- fetch_ready=0 for 3 cycles at pc 0x8000_0020: pc holds with no handshakes. A stale prediction with trigger_pc=0x8000_0018 arriving 2 cycles later is ignored.
- Build without BPU_REDIRECT_EN, matching taken prediction: pc stays sequential and pc_handshake stays 1.
